// File: rtl/spi_pkg.sv
// SPI types shared by master and slave: FSM states, config word field layout, first-bit helper.
package spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT
  } spi_state_t;

  localparam int CFG_LSB_FIRST_BIT = 31;
  localparam int CFG_LEN_LSB       = 8;
  localparam int CFG_LEN_W         = 5;
  localparam int CFG_CSPOL_BIT     = 2;
  localparam int CFG_CPOL_BIT      = 1;
  localparam int CFG_CPHA_BIT      = 0;

  typedef struct packed {
    logic                 lsb_first;
    logic [CFG_LEN_W-1:0] length;
    logic                 cspol;
    logic                 cpol;
    logic                 cpha;
  } spi_cfg_t;

  // Bit that goes on the wire first for a word of (length+1) bits.
  function automatic logic first_bit(input logic [31:0] word, input logic lsb_first,
                                     input logic [CFG_LEN_W-1:0] length);
    return lsb_first ? word[0] : word[length];
  endfunction

endpackage

// File: rtl/spi_input_sync.sv
// Multi-flop synchronizer for the {sck, cs, sdi} pins, plus one extra sck flop for edge detection.
module spi_input_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] pins,
  output logic [2:0] synced,
  output logic       sck_prev
);

  logic [SYNC_STAGES-1:0][2:0] stage;

  always_ff @(posedge clk) begin
    if (reset) begin
      stage    <= '0;
      sck_prev <= 1'b0;
    end else begin
      stage    <= {stage[SYNC_STAGES-2:0], pins};
      sck_prev <= stage[SYNC_STAGES-1][2];
    end
  end

  assign synced = stage[SYNC_STAGES-1];

endmodule

// File: rtl/spi_slave_module.sv
// SPI responder sampled in the CLK100MHZ domain; tx word shifted out on sdo, rx words strobed out.
// Optional tx underrun detection enabled by defining SPI_SLAVE_UNDERRUN_EN.
module spi_slave_module
  import spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        CLK100MHZ,
  input  logic        reset,
  input  logic [31:0] spi_config_in,
  input  logic        spi_config_selected,
  input  logic [31:0] spi_data_in,
  input  logic        spi_data_selected,
  input  logic        sck,
  input  logic        cs,
  input  logic        sdi,
  output logic        sdo,
  output logic        sdo_en,
  output logic        busy,
  output logic [31:0] spi_data_out,
  output logic        data_write,
  output logic        tx_underrun
);

  spi_cfg_t   cfg;
  spi_cfg_t   cfg_in;
  spi_state_t state;
  spi_state_t state_next;

  logic [31:0] tx_buf;
  logic [31:0] shreg;
  logic [31:0] rx;
  logic [4:0]  cnt;
  logic        hold;

  logic [2:0] synced;
  logic       sck_s;
  logic       cs_s;
  logic       sdi_s;
  logic       sck_q;

  logic        cs_active;
  logic        lead_edge;
  logic        trail_edge;
  logic        sample_edge;
  logic        shift_edge;
  logic        word_done;
  logic        cfg_accept;
  logic [31:0] tx_src;
  logic [31:0] rx_next;
  logic [31:0] shifted;
  logic        unused_cfg_bits;

  spi_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk      (CLK100MHZ),
    .reset    (reset),
    .pins     ({sck, cs, sdi}),
    .synced   (synced),
    .sck_prev (sck_q)
  );

  assign {sck_s, cs_s, sdi_s} = synced;

  assign cfg_in = '{
    lsb_first: spi_config_in[CFG_LSB_FIRST_BIT],
    length:    spi_config_in[CFG_LEN_LSB +: CFG_LEN_W],
    cspol:     spi_config_in[CFG_CSPOL_BIT],
    cpol:      spi_config_in[CFG_CPOL_BIT],
    cpha:      spi_config_in[CFG_CPHA_BIT]
  };
  assign unused_cfg_bits = ^{spi_config_in[30:13], spi_config_in[7:3]};

  assign cs_active   = (cs_s == cfg.cspol);
  assign lead_edge   = (sck_s != sck_q) && (sck_q == cfg.cpol);
  assign trail_edge  = (sck_s != sck_q) && (sck_s == cfg.cpol);
  assign sample_edge = cfg.cpha ? trail_edge : lead_edge;
  assign shift_edge  = cfg.cpha ? lead_edge : trail_edge;
  assign word_done   = (state == ST_SHIFT) && cs_active && sample_edge && (cnt == cfg.length);
  assign cfg_accept  = spi_config_selected && !busy;

  // A word written in the same cycle as a reload goes straight into the shifter.
  assign tx_src  = spi_data_selected ? spi_data_in : tx_buf;
  assign rx_next = cfg.lsb_first ? (rx | (32'(sdi_s) << cnt)) : {rx[30:0], sdi_s};
  assign shifted = cfg.lsb_first ? (shreg >> 1) : (shreg << 1);

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    sdo_en     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cs_active) state_next = ST_LOAD;
      end
      ST_LOAD: begin
        busy       = 1'b1;
        sdo_en     = 1'b1;
        state_next = cs_active ? ST_SHIFT : ST_IDLE;
      end
      ST_SHIFT: begin
        busy   = 1'b1;
        sdo_en = 1'b1;
        if (!cs_active) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // hold marks that the next shift edge must present the first bit rather than advance:
  // with cpha=1 it is already on sdo, with cpha=0 after a reload the old last bit is still needed.
  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      cfg          <= '0;
      tx_buf       <= '0;
      shreg        <= '0;
      rx           <= '0;
      cnt          <= '0;
      hold         <= 1'b0;
      sdo          <= 1'b0;
      spi_data_out <= '0;
      data_write   <= 1'b0;
    end else begin
      data_write <= 1'b0;
      if (cfg_accept)        cfg    <= cfg_in;
      if (spi_data_selected) tx_buf <= spi_data_in;

      case (state)
        ST_IDLE: begin
          cnt <= '0;
          rx  <= '0;
          if (cs_active) begin
            shreg <= tx_src;
            sdo   <= first_bit(tx_src, cfg.lsb_first, cfg.length);
            hold  <= cfg.cpha;
          end
        end
        ST_SHIFT: begin
          if (cs_active && sample_edge) begin
            if (cnt == cfg.length) begin
              spi_data_out <= rx_next;
              data_write   <= 1'b1;
              rx           <= '0;
              cnt          <= '0;
              shreg        <= tx_src;
              hold         <= 1'b1;
              if (cfg.cpha) sdo <= first_bit(tx_src, cfg.lsb_first, cfg.length);
            end else begin
              rx  <= rx_next;
              cnt <= cnt + 5'd1;
            end
          end
          if (cs_active && shift_edge) begin
            if (hold) begin
              sdo  <= first_bit(shreg, cfg.lsb_first, cfg.length);
              hold <= 1'b0;
            end else begin
              shreg <= shifted;
              sdo   <= first_bit(shifted, cfg.lsb_first, cfg.length);
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SPI_SLAVE_UNDERRUN_EN
  logic fresh;
  logic load_evt;

  assign load_evt = ((state == ST_IDLE) && cs_active) || word_done;

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      fresh       <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      if (cfg_accept) tx_underrun <= 1'b0;
      if (load_evt) begin
        fresh <= 1'b0;
        if (!fresh && !spi_data_selected) tx_underrun <= 1'b1;
      end else if (spi_data_selected) begin
        fresh <= 1'b1;
      end
    end
  end
`else
  assign tx_underrun = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave_module.sv
// Directed bench: bit-bangs an SPI master against spi_slave_module and checks sdo and rx words.
module tb_spi_slave_module;

  localparam int H = 8;
`ifdef SPI_SLAVE_UNDERRUN_EN
  localparam logic UR_EXP = 1'b1;
`else
  localparam logic UR_EXP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] cfg_in;
  logic        cfg_sel;
  logic [31:0] data_in;
  logic        data_sel;
  logic        sck, cs, sdi;
  logic        sdo, sdo_en, busy, data_write, tx_underrun;
  logic [31:0] spi_data_out;

  int total = 0;
  int bad = 0;
  int dw_count = 0;
  logic [31:0] rx_log [16];
  logic [31:0] m1, m2;

  spi_slave_module #(.SYNC_STAGES(2)) dut (
    .CLK100MHZ           (clk),
    .reset               (reset),
    .spi_config_in       (cfg_in),
    .spi_config_selected (cfg_sel),
    .spi_data_in         (data_in),
    .spi_data_selected   (data_sel),
    .sck                 (sck),
    .cs                  (cs),
    .sdi                 (sdi),
    .sdo                 (sdo),
    .sdo_en              (sdo_en),
    .busy                (busy),
    .spi_data_out        (spi_data_out),
    .data_write          (data_write),
    .tx_underrun         (tx_underrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (data_write) begin
      if (dw_count < 16) rx_log[dw_count] = spi_data_out;
      dw_count++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_cfg(input logic [31:0] c);
    cfg_in = c; cfg_sel = 1'b1; cyc(1); cfg_sel = 1'b0;
  endtask

  task automatic load_tx(input logic [31:0] d);
    data_in = d; data_sel = 1'b1; cyc(1); data_sel = 1'b0;
  endtask

  task automatic xfer(input logic cpol, input logic cpha, input logic lsb, input int len,
                      input logic [31:0] mosi, input int nbits, input logic ld_en,
                      input logic [31:0] ld_word, output logic [31:0] miso);
    miso = '0;
    for (int i = 0; i < nbits; i++) begin
      int b;
      b = lsb ? i : len - i;
      if (ld_en && i == 2) load_tx(ld_word);
      if (!cpha) begin
        sdi = mosi[b]; cyc(H); sck = ~cpol; miso[b] = sdo; cyc(H); sck = cpol;
      end else begin
        sck = ~cpol; sdi = mosi[b]; cyc(H); sck = cpol; miso[b] = sdo; cyc(H);
      end
    end
  endtask

  initial begin
    reset = 1'b1; cfg_in = '0; cfg_sel = 1'b0; data_in = '0; data_sel = 1'b0;
    sck = 1'b0; cs = 1'b1; sdi = 1'b0;
    cyc(3);
    reset = 1'b0;
    check("rst_sdo", 32'(sdo), 32'd0);
    check("rst_sdo_en", 32'(sdo_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_data_out", spi_data_out, 32'd0);
    check("rst_data_write", 32'(data_write), 32'd0);
    check("rst_underrun", 32'(tx_underrun), 32'd0);
    cyc(8);

    // Mode 0, msb-first, 8 bits
    set_cfg(32'h0000_0700);
    load_tx(32'hA5);
    cs = 1'b0; cyc(H);
    check("m0_busy", 32'(busy), 32'd1);
    check("m0_sdo_en", 32'(sdo_en), 32'd1);
    xfer(1'b0, 1'b0, 1'b0, 7, 32'h3C, 8, 1'b0, '0, m1);
    cyc(H);
    check("m0_miso", m1, 32'hA5);
    check("m0_rx", spi_data_out, 32'h3C);
    check("m0_dw", 32'(dw_count), 32'd1);
    cs = 1'b1; cyc(H);
    check("m0_idle_sdo_en", 32'(sdo_en), 32'd0);
    check("m0_idle_busy", 32'(busy), 32'd0);

    // Mode 3, lsb-first, 16 bits
    sck = 1'b1; cyc(H);
    set_cfg(32'h8000_0F03);
    load_tx(32'h1234);
    cs = 1'b0; cyc(H);
    xfer(1'b1, 1'b1, 1'b1, 15, 32'hBEEF, 16, 1'b0, '0, m1);
    cyc(H);
    check("m3_miso", m1, 32'h1234);
    check("m3_rx", spi_data_out, 32'h0000BEEF);
    check("m3_dw", 32'(dw_count), 32'd2);
    cs = 1'b1; cyc(H);

    // Two words under one cs, new tx word loaded during the first
    sck = 1'b0; cyc(H);
    set_cfg(32'h0000_0700);
    load_tx(32'h96);
    cs = 1'b0; cyc(H);
    xfer(1'b0, 1'b0, 1'b0, 7, 32'h11, 8, 1'b1, 32'h55, m1);
    xfer(1'b0, 1'b0, 1'b0, 7, 32'h22, 8, 1'b0, '0, m2);
    cyc(H);
    cs = 1'b1; cyc(H);
    check("b2b_miso0", m1, 32'h96);
    check("b2b_miso1", m2, 32'h55);
    check("b2b_dw", 32'(dw_count), 32'd4);
    check("b2b_rx0", rx_log[2], 32'h11);
    check("b2b_rx1", rx_log[3], 32'h22);

    // Abort after 4 bits
    cs = 1'b0; cyc(H);
    xfer(1'b0, 1'b0, 1'b0, 7, 32'hFF, 4, 1'b0, '0, m1);
    cs = 1'b1; cyc(4);
    check("abort_sdo_en", 32'(sdo_en), 32'd0);
    check("abort_dw", 32'(dw_count), 32'd4);
    check("abort_miso", m1, 32'h50);
    cyc(H);
    cs = 1'b0; cyc(H);
    xfer(1'b0, 1'b0, 1'b0, 7, 32'hC3, 8, 1'b0, '0, m1);
    cyc(H);
    cs = 1'b1; cyc(H);
    check("after_abort_miso", m1, 32'h55);
    check("after_abort_rx", spi_data_out, 32'hC3);
    check("after_abort_dw", 32'(dw_count), 32'd5);

    // Config write while busy must be ignored
    cs = 1'b0; cyc(H);
    set_cfg(32'h8000_0F03);
    xfer(1'b0, 1'b0, 1'b0, 7, 32'h5A, 8, 1'b0, '0, m1);
    cyc(H);
    check("cfgbusy_miso", m1, 32'h55);
    check("cfgbusy_rx", spi_data_out, 32'h5A);
    check("cfgbusy_dw", 32'(dw_count), 32'd6);
    cs = 1'b1; cyc(H);

    // Reset in the middle of a word
    cs = 1'b0; cyc(H);
    xfer(1'b0, 1'b0, 1'b0, 7, 32'hFF, 3, 1'b0, '0, m1);
    reset = 1'b1; cyc(1); reset = 1'b0;
    check("midrst_sdo", 32'(sdo), 32'd0);
    check("midrst_sdo_en", 32'(sdo_en), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_data_out", spi_data_out, 32'd0);
    check("midrst_data_write", 32'(data_write), 32'd0);
    check("midrst_underrun", 32'(tx_underrun), 32'd0);
    check("midrst_dw", 32'(dw_count), 32'd6);
    cs = 1'b1; sck = 1'b0; cyc(H);

    // 1-bit words, retransmit without reload, underrun flag
    set_cfg(32'h0000_0000);
    load_tx(32'h1);
    cs = 1'b0; cyc(H);
    check("ur_first_load", 32'(tx_underrun), 32'd0);
    xfer(1'b0, 1'b0, 1'b0, 0, 32'h1, 1, 1'b0, '0, m1);
    cyc(H);
    cs = 1'b1;
    check("len0_miso0", m1, 32'h1);
    check("len0_rx0", spi_data_out, 32'h1);
    check("len0_dw0", 32'(dw_count), 32'd7);
    cyc(H);
    cs = 1'b0; cyc(H);
    xfer(1'b0, 1'b0, 1'b0, 0, 32'h0, 1, 1'b0, '0, m1);
    cyc(H);
    cs = 1'b1;
    check("len0_miso1", m1, 32'h1);
    check("len0_rx1", spi_data_out, 32'h0);
    check("len0_dw1", 32'(dw_count), 32'd8);
    check("ur_second_frame", 32'(tx_underrun), 32'(UR_EXP));
    cyc(H);
    set_cfg(32'h0000_0700);
    check("ur_cleared", 32'(tx_underrun), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_slave_module.md
# spi_slave_module

SPI responder: the far end of the SPI master FSM, for FPGA-to-FPGA links and loop-back verification of the master. Samples externally driven `sck`, `cs`, `sdi` in the `CLK100MHZ` domain, shifts a host-loaded word out on `sdo`, and hands each received word to the host bus with a one-cycle `data_write` strobe. Config word layout and mode semantics match the master's, so one driver serves both ends.

## Interface
- `SYNC_STAGES`, 2: synchronizer flops on `sck`, `cs`, `sdi` (min 2).
- `CLK100MHZ` in 1: system clock.
- `reset` in 1: one clock; reset is synchronous and active-high.
- `spi_config_in` in 32: [31] lsb_first, [12:8] length (bits per word = length+1), [2] cspol, [1] cpol, [0] cpha; other bits reserved, ignored.
- `spi_config_selected` in 1: latch `spi_config_in`; ignored while `busy`=1.
- `spi_data_in` in 32: transmit word.
- `spi_data_selected` in 1: latch `spi_data_in` into tx buffer; accepted any cycle.
- `sck`, `cs`, `sdi` in 1 each: asynchronous pins.
- `sdo` out 1: serial output.
- `sdo_en` out 1: output enable for pad tristate; 1 only while selected.
- `busy` out 1: 1 while `cs` active (synchronized).
- `spi_data_out` out 32: last completed rx word, right-aligned, upper bits 0.
- `data_write` out 1: one-cycle strobe, `spi_data_out` new in same cycle.
- `tx_underrun` out 1: sticky (only with macro, see Configuration).

## Operation
- Synchronized `cs` active when equal to `cspol`. Leading edge: `sck` leaves `cpol`; trailing edge: returns to `cpol`.
- Sample edge = leading if cpha=0, trailing if cpha=1; shift edge = the other.
- States: IDLE, LOAD, SHIFT.
- IDLE: `sdo_en`=0, `busy`=0, bit counter 0. cs active -> LOAD.
- LOAD (one cycle): shift register <- tx buffer, bit counter <- 0, `sdo_en`=1, `busy`=1, first bit (bit `length` if msb-first, bit 0 if lsb-first) on `sdo`; -> SHIFT.
- SHIFT: sample edge shifts synchronized `sdi` into rx register; shift edge advances `sdo` — except with cpha=1 the first leading edge of a word does not advance (first bit already presented).
- Sample edge with counter == length: `spi_data_out` <- rx word, pulse `data_write`, reload shift register from tx buffer, counter <- 0, stay SHIFT (back-to-back words under one cs).
- cs inactive in LOAD/SHIFT: -> IDLE next cycle; partial word discarded, no `data_write`, `sdo_en`=0.
- `spi_data_selected` in the same cycle as a reload: reload takes the new `spi_data_in`.
- No new tx word since last load: retransmit tx buffer unchanged.
- Counter 5 bits, compare to length; length 0 (1-bit word) legal.
- Reset values: `sdo`=0, `sdo_en`=0, `busy`=0, `spi_data_out`=0, `data_write`=0, `tx_underrun`=0, config=0, tx buffer=0, state IDLE. Reset mid-word aborts immediately, no strobe.

## Timing
- Pin-to-detect latency: SYNC_STAGES+1 cycles. `sdo` changes 1 cycle after edge detect (SYNC_STAGES+2 after pin edge).
- `data_write` asserts 1 cycle after the final sample edge is detected.
- Requirement: `sck` high and low each >= SYNC_STAGES+3 cycles (5 at default, sck <= 10 MHz); cs-assert to first sck edge >= SYNC_STAGES+3 cycles.
- Config latch: 1 cycle after `spi_config_selected`; data latch likewise.

## Configuration
- `SPI_SLAVE_UNDERRUN_EN` defined: `tx_underrun` sets when LOAD or a reload occurs with no `spi_data_selected` since the previous load; cleared by an accepted config write or reset.
- Undefined: no detection logic, `tx_underrun` tied 0.

## Structure
- Shared package `spi_pkg`: state enum, config field bit positions/widths, shared with the master.
- Sub-module `spi_input_sync`: SYNC_STAGES-deep synchronizer, 3-bit vector, plus registered `sck` for edge detect.

## Test plan
- Mode 0, msb-first, length 7, tx 0xA5; master sends 0x3C -> `sdo` 1,0,1,0,0,1,0,1; `spi_data_out`=0x3C, one `data_write` pulse.
- Mode 3, lsb-first, length 15, tx 0x1234, rx 0xBEEF -> `sdo` LSB first 0x1234; `spi_data_out`=0x0000BEEF.
- cs held for two 8-bit words, new tx 0x55 loaded mid-first-word -> second word sends 0x55; two `data_write` pulses.
- cs deasserted after 4 of 8 bits -> no `data_write`, `sdo_en` 0 within SYNC_STAGES+2 cycles, next frame correct.
- `spi_config_selected` while busy -> config unchanged; reset mid-word -> all outputs at reset values next cycle.
- Macro defined, two frames without reloading tx -> `tx_underrun`=1 at second LOAD, cleared by config write.
